// File: rtl/bcd_display_feeder.sv
// Sequential binary-to-BCD converter feeding the 4-digit seven-segment driver.
// Decimal mode runs a 16-iteration double dabble; hex mode passes the value
// straight through. Values above 9999 are replaced by OVF_PATTERN.
module bcd_display_feeder #(
  parameter logic [15:0] OVF_PATTERN = 16'hEEEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin_value,
  input  logic        hex_mode,
  output logic        busy,
  output logic        overflow,
  output logic [15:0] displayed_number,
  output logic        display_sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_bin;
  logic [19:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [19:0] w_bcd_adj;

  // Add-3 correction on every BCD digit that is 5 or more, ahead of the shift
  always_comb begin
    w_bcd_adj = '0;
    for (int unsigned d = 0; d < 5; d++) begin
      w_bcd_adj[4*d +: 4] = (r_bcd[4*d +: 4] >= 4'd5) ? (r_bcd[4*d +: 4] + 4'd3)
                                                       : r_bcd[4*d +: 4];
    end
  end

  // Control FSM, shift/accumulate datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_bin            <= '0;
      r_bcd            <= '0;
      r_cnt            <= '0;
      busy             <= 1'b0;
      overflow         <= 1'b0;
      displayed_number <= '0;
      display_sel      <= 1'b0;
    end else begin
      display_sel <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (hex_mode) begin
              displayed_number <= bin_value;
              display_sel      <= 1'b1;
              overflow         <= 1'b0;
            end else begin
              r_bin   <= bin_value;
              r_bcd   <= '0;
              r_cnt   <= '0;
              busy    <= 1'b1;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_bcd_adj[18:0], r_bin[15]};
          r_bin <= {r_bin[14:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // With a 16-bit source, a nonzero fifth digit is exactly value >= 10000
          if (r_bcd[19:16] != 4'd0) begin
            displayed_number <= OVF_PATTERN;
            overflow         <= 1'b1;
          end else begin
            displayed_number <= r_bcd[15:0];
            overflow         <= 1'b0;
          end
          display_sel <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
